lsu_ctrl: RTL and testbench



---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and types for the load/store unit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package lsu_pkg;

    // RISC-V major opcodes handled by the unit
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // funct3 encodings: bits [1:0] give the size, bit 2 selects zero-extension
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: byte enables, store-data shift, load extract/extend, misalignment flag.
// Latency: purely combinational.
// Backpressure: none, no state.
//
// Ports: size (access size), sext (sign-extend loads), offset (byte offset in the word),
//        wdata_in/rdata_in (raw store data, full memory word) -> be, wdata, rdata_ext, misaligned.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NBYTES = XLEN / 8,
    localparam int OFFW   = $clog2(NBYTES)
) (
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [OFFW-1:0]   offset,
    input  logic [XLEN-1:0]   wdata_in,
    input  logic [XLEN-1:0]   rdata_in,
    output logic [NBYTES-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata_ext,
    output logic              misaligned
);

    logic [NBYTES-1:0] mask;
    logic [XLEN-1:0]   shifted;

    always_comb begin
        mask       = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        // Bring the addressed lane down to bit 0 before truncating.
        shifted    = rdata_in >> {offset, 3'b000};
        case (size_t'(size))
            SZ_B: begin
                mask      = NBYTES'(1);
                rdata_ext = sext ? XLEN'($signed(shifted[7:0])) : XLEN'(shifted[7:0]);
            end
            SZ_H: begin
                mask       = NBYTES'(2'b11);
                rdata_ext  = sext ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
                misaligned = offset[0];
            end
            SZ_W: begin
                mask       = NBYTES'(4'hF);
                rdata_ext  = sext ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
                misaligned = |offset[1:0];
            end
            SZ_D: begin
                // Only reachable as a legal access when XLEN is 64.
                mask       = '1;
                rdata_ext  = shifted;
                misaligned = (offset != '0);
            end
            default: begin
                mask = '0;
            end
        endcase
        be    = mask << offset;
        wdata = wdata_in << {offset, 3'b000};
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Sequential load/store unit: decode, EA, one data-memory transaction, aligned/extended result.
// Latency: legal access 3 cycles accept->out_valid with zero-wait memory; illegal/misaligned 1 cycle.
// Backpressure: holds mem request until mem_req_ready, holds result until out_ready; in_ready only in IDLE.
//
// Ports: in_valid/in_ready + opcode/funct3/imm/rs1/rs2 from execute;
//        mem_req_valid/mem_req_ready + mem_addr/mem_we/mem_be/mem_wdata, mem_rsp_valid/mem_rdata to memory;
//        out_valid/out_ready + out_data/out_err to the consumer.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 12,
    localparam int NBYTES = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [IMM_W-1:0]  imm,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [NBYTES-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic              out_err
);

    localparam int OFFW = $clog2(NBYTES);

    lsu_state_t state, nstate;

    // Access attributes kept for the load extract in WAIT
    logic [1:0]      size_q;
    logic            sext_q;
    logic [OFFW-1:0] off_q;

    logic [XLEN-1:0] ea;
    logic            is_load, is_store, f3_ok, req_err;

    logic [1:0]        al_size;
    logic              al_sext;
    logic [OFFW-1:0]   al_off;
    logic [NBYTES-1:0] al_be;
    logic [XLEN-1:0]   al_wdata, al_rdata;
    logic              al_mis;

    // Effective address wraps modulo 2^XLEN.
    assign ea       = rs1 + XLEN'($signed(imm));
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);

    always_comb begin
        f3_ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = is_load;
            F3_D:             f3_ok = (XLEN == 64);
            F3_WU:            f3_ok = is_load && (XLEN == 64);
            default:          f3_ok = 1'b0;
        endcase
    end

    assign req_err = !(is_load || is_store) || !f3_ok || al_mis;

    // The single aligner serves the incoming request in IDLE (be, wdata,
    // misalignment) and the latched request afterwards (load extract).
    always_comb begin
        if (state == IDLE) begin
            al_size = funct3[1:0];
            al_sext = !funct3[2];
            al_off  = ea[OFFW-1:0];
        end else begin
            al_size = size_q;
            al_sext = sext_q;
            al_off  = off_q;
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .size       (al_size),
        .sext       (al_sext),
        .offset     (al_off),
        .wdata_in   (rs2),
        .rdata_in   (mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate        = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nstate = req_err ? DONE : REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) nstate = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) nstate = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
            size_q    <= '0;
            sext_q    <= 1'b0;
            off_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_data <= '0;
                        out_err  <= req_err;
                        if (!req_err) begin
                            mem_addr  <= ea & ~XLEN'(NBYTES - 1);
                            mem_we    <= is_store;
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                            size_q    <= funct3[1:0];
                            sext_q    <= !funct3[2];
                            off_q     <= ea[OFFW-1:0];
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) out_data <= mem_we ? '0 : al_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [31:0] rs1, rs2;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_data;

    logic        in_valid_64, in_ready_64;
    logic [6:0]  opcode_64;
    logic [2:0]  funct3_64;
    logic [11:0] imm_64;
    logic [63:0] rs1_64, rs2_64;
    logic        mem_req_valid_64, mem_req_ready_64, mem_we_64, mem_rsp_valid_64;
    logic [63:0] mem_addr_64, mem_wdata_64, mem_rdata_64;
    logic [7:0]  mem_be_64;
    logic        out_valid_64, out_ready_64, out_err_64;
    logic [63:0] out_data_64;

    int checks = 0;
    int fails  = 0;
    int txn    = 0;
    int req_cycles = 0;

    lsu_ctrl #(.XLEN(32), .IMM_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .imm(imm), .rs1(rs1), .rs2(rs2),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    lsu_ctrl #(.XLEN(64), .IMM_W(12)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_64), .in_ready(in_ready_64),
        .opcode(opcode_64), .funct3(funct3_64), .imm(imm_64), .rs1(rs1_64), .rs2(rs2_64),
        .mem_req_valid(mem_req_valid_64), .mem_req_ready(mem_req_ready_64), .mem_addr(mem_addr_64),
        .mem_we(mem_we_64), .mem_be(mem_be_64), .mem_wdata(mem_wdata_64),
        .mem_rsp_valid(mem_rsp_valid_64), .mem_rdata(mem_rdata_64),
        .out_valid(out_valid_64), .out_ready(out_ready_64), .out_data(out_data_64), .out_err(out_err_64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) txn++;
        if (mem_req_valid) req_cycles++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] im,
                         input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1; opcode = op; funct3 = f3; imm = im; rs1 = a; rs2 = d;
        step();
        in_valid = 1'b0;
    endtask

    // Accept the pending request, then return one response word.
    task automatic mem_cycle(input logic [31:0] rd);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = rd;
        step();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
        checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin fails++; $display("FAIL reset_out got=%b/%b exp=0/0", out_valid, out_err); end
        checks++; if (out_data !== 32'h0 || mem_addr !== 32'h0 || mem_be !== 4'h0) begin fails++; $display("FAIL reset_regs got=%h/%h/%h exp=0", out_data, mem_addr, mem_be); end
    endtask

    task automatic test_lb();
        issue(7'b0000011, 3'b000, 12'h003, 32'h1000, 32'h0);
        checks++; if (mem_req_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL lb_req got=%b/%b exp=1/0", mem_req_valid, in_ready); end
        checks++; if (mem_addr !== 32'h1000) begin fails++; $display("FAIL lb_addr got=%h exp=00001000", mem_addr); end
        checks++; if (mem_be !== 4'b1000 || mem_we !== 1'b0) begin fails++; $display("FAIL lb_be got=%b we=%b exp=1000 we=0", mem_be, mem_we); end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL lb_wait got=%b/%b exp=0/0", mem_req_valid, out_valid); end
        mem_rsp_valid = 1'b1; mem_rdata = 32'h80FF_1234;
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lb_latency out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'hFFFF_FF80 || out_err !== 1'b0) begin fails++; $display("FAIL lb_data got=%h err=%b exp=ffffff80 err=0", out_data, out_err); end
        drain();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL lb_idle got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_lhu();
        issue(7'b0000011, 3'b101, 12'hFFE, 32'h2000, 32'h0);
        checks++; if (mem_addr !== 32'h1FFC || mem_be !== 4'b1100) begin fails++; $display("FAIL lhu_req got=%h/%b exp=00001ffc/1100", mem_addr, mem_be); end
        mem_cycle(32'hBEEF_0000);
        checks++; if (out_data !== 32'h0000_BEEF || out_err !== 1'b0) begin fails++; $display("FAIL lhu_data got=%h err=%b exp=0000beef err=0", out_data, out_err); end
        drain();
    endtask

    task automatic test_sb();
        issue(7'b0100011, 3'b000, 12'h001, 32'h10, 32'hAB);
        checks++; if (mem_we !== 1'b1 || mem_be !== 4'b0010) begin fails++; $display("FAIL sb_req got we=%b be=%b exp we=1 be=0010", mem_we, mem_be); end
        checks++; if (mem_wdata !== 32'h0000_AB00 || mem_addr !== 32'h10) begin fails++; $display("FAIL sb_wdata got=%h addr=%h exp=0000ab00 addr=00000010", mem_wdata, mem_addr); end
        mem_cycle(32'h1234_5678);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0) begin fails++; $display("FAIL sb_ack got=%b/%h exp=1/00000000", out_valid, out_data); end
        drain();
    endtask

    task automatic test_wrap();
        // 0xFFFFFFFF + 1 wraps to address 0, lane 0
        issue(7'b0000011, 3'b100, 12'h001, 32'hFFFF_FFFF, 32'h0);
        checks++; if (mem_addr !== 32'h0 || mem_be !== 4'b0001) begin fails++; $display("FAIL wrap_req got=%h/%b exp=00000000/0001", mem_addr, mem_be); end
        mem_cycle(32'h0000_00F0);
        checks++; if (out_data !== 32'h0000_00F0) begin fails++; $display("FAIL wrap_lbu got=%h exp=000000f0", out_data); end
        drain();
    endtask

    task automatic test_errors();
        int rc0;
        rc0 = req_cycles;
        issue(7'b0000011, 3'b010, 12'h002, 32'h1000, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin fails++; $display("FAIL lw_mis got=%b/%b exp=1/1", out_valid, out_err); end
        checks++; if (mem_req_valid !== 1'b0 || out_data !== 32'h0) begin fails++; $display("FAIL lw_mis_noreq got=%b/%h exp=0/0", mem_req_valid, out_data); end
        drain();
        issue(7'b0110011, 3'b010, 12'h000, 32'h1000, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin fails++; $display("FAIL bad_opcode got=%b/%b exp=1/1", out_valid, out_err); end
        drain();
        issue(7'b0100011, 3'b011, 12'h000, 32'h1000, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin fails++; $display("FAIL sd_rv32 got=%b/%b exp=1/1", out_valid, out_err); end
        drain();
        issue(7'b0000011, 3'b001, 12'h001, 32'h1000, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin fails++; $display("FAIL lh_mis got=%b/%b exp=1/1", out_valid, out_err); end
        drain();
        checks++; if (req_cycles !== rc0) begin fails++; $display("FAIL err_no_mem got=%0d exp=%0d", req_cycles, rc0); end
    endtask

    task automatic test_backpressure();
        int t0;
        t0 = txn;
        issue(7'b0000011, 3'b001, 12'h006, 32'h3000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h3004 || mem_be !== 4'b1100 || mem_we !== 1'b0) begin
                fails++; $display("FAIL bp_req_hold cyc=%0d got=%b/%h/%b exp=1/00003004/1100", i, mem_req_valid, mem_addr, mem_be); end
            step();
        end
        mem_cycle(32'h8001_5555);
        mem_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_8001) begin
                fails++; $display("FAIL bp_out_hold cyc=%0d got=%b/%h exp=1/ffff8001", i, out_valid, out_data); end
            step();
        end
        drain();
        checks++; if (out_valid !== 1'b0 || (txn - t0) !== 1) begin fails++; $display("FAIL bp_txn got=%b/%0d exp=0/1", out_valid, txn - t0); end
    endtask

    task automatic test_reset_mid();
        issue(7'b0000011, 3'b010, 12'h000, 32'h4000, 32'h0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_hs got=%b/%b/%b exp=1/0/0", in_ready, mem_req_valid, out_valid); end
        checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || out_data !== 32'h0 || out_err !== 1'b0) begin fails++; $display("FAIL rst_mid_regs got=%h/%b/%h/%b exp=0", mem_addr, mem_be, out_data, out_err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rsp_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rst_late_rsp got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_xlen64();
        in_valid_64 = 1'b1; opcode_64 = 7'b0000011; funct3_64 = 3'b011; imm_64 = 12'h008; rs1_64 = 64'h0;
        step();
        in_valid_64 = 1'b0;
        checks++; if (mem_req_valid_64 !== 1'b1 || mem_addr_64 !== 64'h8 || mem_be_64 !== 8'hFF) begin
            fails++; $display("FAIL ld64_req got=%b/%h/%h exp=1/0000000000000008/ff", mem_req_valid_64, mem_addr_64, mem_be_64); end
        mem_req_ready_64 = 1'b1; step(); mem_req_ready_64 = 1'b0;
        mem_rsp_valid_64 = 1'b1; mem_rdata_64 = 64'h8000_0000_0000_0001; step(); mem_rsp_valid_64 = 1'b0;
        checks++; if (out_valid_64 !== 1'b1 || out_data_64 !== 64'h8000_0000_0000_0001 || out_err_64 !== 1'b0) begin
            fails++; $display("FAIL ld64_data got=%b/%h/%b exp=1/8000000000000001/0", out_valid_64, out_data_64, out_err_64); end
        out_ready_64 = 1'b1; step(); out_ready_64 = 1'b0;
        // LW in the upper half of a doubleword, sign-extended to 64 bits
        in_valid_64 = 1'b1; funct3_64 = 3'b010; imm_64 = 12'h004; rs1_64 = 64'h10;
        step();
        in_valid_64 = 1'b0;
        checks++; if (mem_addr_64 !== 64'h10 || mem_be_64 !== 8'hF0) begin fails++; $display("FAIL lw64_req got=%h/%h exp=0000000000000010/f0", mem_addr_64, mem_be_64); end
        mem_req_ready_64 = 1'b1; step(); mem_req_ready_64 = 1'b0;
        mem_rsp_valid_64 = 1'b1; mem_rdata_64 = 64'h8000_0000_0000_0000; step(); mem_rsp_valid_64 = 1'b0;
        checks++; if (out_data_64 !== 64'hFFFF_FFFF_8000_0000) begin fails++; $display("FAIL lw64_data got=%h exp=ffffffff80000000", out_data_64); end
        out_ready_64 = 1'b1; step(); out_ready_64 = 1'b0;
        // LD at EA=4 is misaligned
        in_valid_64 = 1'b1; funct3_64 = 3'b011; imm_64 = 12'h004; rs1_64 = 64'h0;
        step();
        in_valid_64 = 1'b0;
        checks++; if (out_valid_64 !== 1'b1 || out_err_64 !== 1'b1 || mem_req_valid_64 !== 1'b0) begin
            fails++; $display("FAIL ld64_mis got=%b/%b/%b exp=1/1/0", out_valid_64, out_err_64, mem_req_valid_64); end
        out_ready_64 = 1'b1; step(); out_ready_64 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; opcode = '0; funct3 = '0; imm = '0; rs1 = '0; rs2 = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        in_valid_64 = 1'b0; opcode_64 = '0; funct3_64 = '0; imm_64 = '0; rs1_64 = '0; rs2_64 = '0;
        mem_req_ready_64 = 1'b0; mem_rsp_valid_64 = 1'b0; mem_rdata_64 = '0; out_ready_64 = 1'b0;
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        test_lb();
        test_lhu();
        test_sb();
        test_wrap();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_xlen64();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
